// File: rtl/ec11b_key_ctrl.sv
// EC11B push-switch front end: synchroniser, debouncer and short/long press classifier with a stretched clear.
// Optional auto-repeat of long_o while held is built when EC11B_KEY_AUTOREP_EN is defined.
`timescale 1ns/1ps
module ec11b_key_ctrl #(
    parameter int CLK_HZ      = 50_000_000,
    parameter int DEB_MS      = 20,
    parameter int LONG_MS     = 1000,
    parameter int CLR_HOLD_MS = 5
`ifdef EC11B_KEY_AUTOREP_EN
    ,
    parameter int REP_MS      = 200
`endif
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       d_i,
    output logic       key_o,
    output logic       short_o,
    output logic       long_o,
    output logic       clr_o,
    output logic [7:0] press_cnt_o8,
    output logic [2:0] state_o3
);
    localparam int TICK_DIV = CLK_HZ / 1000;
    localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [7:0]  DEB_V  = 8'(DEB_MS);
    localparam logic [15:0] LONG_V = 16'(LONG_MS);
    localparam logic [7:0]  CLR_V  = 8'(CLR_HOLD_MS);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_DEB_DN    = 3'd1,
        S_HELD      = 3'd2,
        S_LONG_HELD = 3'd3,
        S_DEB_UP    = 3'd4,
        S_DEB_UP_L  = 3'd5
    } state_t;

    state_t        state, state_next;
    logic          sync_1, sync_d, sync_q;
    logic [TW-1:0] tick_cnt;
    logic          tick, pressed, changed, stable;
    logic [7:0]    deb_cnt;
    logic [15:0]   hold_cnt;
    logic [7:0]    clr_cnt;
    logic          key_next, short_next, long_first, long_rep;

    assign tick     = (tick_cnt == TICK_LAST);
    assign pressed  = ~sync_d;
    assign changed  = (sync_d != sync_q);
    assign stable   = (deb_cnt == DEB_V);
    assign state_o3 = state;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_1   <= 1'b1;
            sync_d   <= 1'b1;
            sync_q   <= 1'b1;
            tick_cnt <= '0;
            deb_cnt  <= '0;
        end else begin
            sync_1   <= d_i;
            sync_d   <= sync_1;
            sync_q   <= sync_d;
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            // Any edge restarts the debounce window, even on a tick; saturating keeps "stable" asserted.
            if (changed)
                deb_cnt <= '0;
            else if (tick && !stable)
                deb_cnt <= deb_cnt + 1'b1;
        end
    end

`ifdef EC11B_KEY_AUTOREP_EN
    localparam logic [15:0] REP_V = 16'(REP_MS);
    logic [15:0] rep_cnt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            rep_cnt <= '0;
        else if ((state_next == S_LONG_HELD && state != S_LONG_HELD) || long_rep)
            rep_cnt <= '0;
        else if (state == S_LONG_HELD && tick && rep_cnt != 16'hFFFF)
            rep_cnt <= rep_cnt + 1'b1;
    end
`endif

    always_comb begin
        state_next = state;
        key_next   = key_o;
        short_next = 1'b0;
        long_first = 1'b0;
        long_rep   = 1'b0;
        case (state)
            S_IDLE:
                if (pressed) state_next = S_DEB_DN;
            S_DEB_DN:
                if (!pressed) state_next = S_IDLE;
                else if (stable) begin
                    state_next = S_HELD;
                    key_next   = 1'b1;
                end
            // >= so a hold that crossed the threshold during a bounce still qualifies on return.
            S_HELD:
                if (!pressed) state_next = S_DEB_UP;
                else if (hold_cnt >= LONG_V) begin
                    state_next = S_LONG_HELD;
                    long_first = 1'b1;
                end
            S_LONG_HELD: begin
                if (!pressed) state_next = S_DEB_UP_L;
`ifdef EC11B_KEY_AUTOREP_EN
                else if (rep_cnt == REP_V) long_rep = 1'b1;
`endif
            end
            S_DEB_UP:
                if (pressed) state_next = S_HELD;
                else if (stable) begin
                    state_next = S_IDLE;
                    key_next   = 1'b0;
                    short_next = 1'b1;
                end
            S_DEB_UP_L:
                if (pressed) state_next = S_LONG_HELD;
                else if (stable) begin
                    state_next = S_IDLE;
                    key_next   = 1'b0;
                end
            default:
                state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state        <= S_IDLE;
            key_o        <= 1'b0;
            short_o      <= 1'b0;
            long_o       <= 1'b0;
            hold_cnt     <= '0;
            press_cnt_o8 <= '0;
        end else begin
            state   <= state_next;
            key_o   <= key_next;
            short_o <= short_next;
            long_o  <= long_first | long_rep;
            if (state == S_DEB_DN && state_next == S_HELD)
                hold_cnt <= '0;
            else if (tick && hold_cnt != 16'hFFFF)
                hold_cnt <= hold_cnt + 1'b1;
            if (short_next)
                press_cnt_o8 <= press_cnt_o8 + 1'b1;
        end
    end

    // Only the first long_o of a press (re)starts the clear stretch.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            clr_o   <= 1'b0;
            clr_cnt <= '0;
        end else if (long_first) begin
            clr_o   <= 1'b1;
            clr_cnt <= '0;
        end else if (clr_o) begin
            if (clr_cnt == CLR_V)
                clr_o <= 1'b0;
            else if (tick)
                clr_cnt <= clr_cnt + 1'b1;
        end
    end
endmodule
